// File: rtl/neuron_pkg.sv
// Shared types, load-port encodings and parameter helpers for the neuron dot-product engine.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_WEIGHT = 2'd1;
  localparam logic [1:0] SEL_BIAS   = 2'd2;
  localparam logic [1:0] SEL_NONE   = 2'd3;

  // Smallest accumulator that holds LANES full-width products without losing the sum.
  function automatic int min_acc_w(input int lanes, input int data_w);
    return 2 * data_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/neuron_dot_engine_byte_serializer.sv
// Loads a WIDTH-bit word and streams it out MSB-first as bytes over valid/ready.
module byte_serializer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    idx_r;
  logic             valid_r;
  logic             fire_s;

  assign fire_s    = valid_r & out_ready;
  assign last      = fire_s & (idx_r == LAST_IDX);
  assign out_byte  = shift_r[WIDTH-1 -: 8];
  assign out_valid = valid_r;

  // Byte shifter: the head byte stays put until the consumer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {WIDTH{1'b0}};
      idx_r   <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= word;
      idx_r   <= {CW{1'b0}};
      valid_r <= 1'b1;
    end else if (fire_s) begin
      shift_r <= shift_r << 4'd8;
      idx_r   <= idx_r + CW'(1);
      if (idx_r == LAST_IDX) begin
        valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/neuron_dot_engine.sv
// Single-neuron engine: byte-loaded lanes and bias, one shared MAC, optional ReLU, byte-serial result.
module neuron_dot_engine
  import neuron_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [1:0] in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  input  logic       signed_mode,
  input  logic       relu_en,
  output logic       busy,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done
);

  if (LANES < 2 || DATA_W < 2 || DATA_W > 8 || (ACC_W % 8) != 0 ||
      ACC_W < min_acc_w(LANES, DATA_W)) begin : g_param_err
    $error("neuron_dot_engine: illegal LANES/DATA_W/ACC_W combination");
  end

  localparam int CNT_W = $clog2(LANES);
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_t state_r, state_nxt_s;

  logic [DATA_W-1:0] data_r   [LANES];
  logic [DATA_W-1:0] weight_r [LANES];
  logic [ACC_W-1:0]  bias_r, bias_nxt_s;
  logic [ACC_W-1:0]  acc_r, result_s;
  logic [CNT_W-1:0]  lane_r;
  logic              signed_r, relu_r, loaded_r, done_r;
  logic              load_fire_s, ser_load_s, ser_last_s;
  logic signed [DATA_W:0]   op_a_s, op_b_s;
  logic signed [PROD_W-1:0] prod_s;

  assign in_ready    = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign load_fire_s = in_valid & in_ready;
  assign ser_load_s  = (state_r == OUT) & ~loaded_r;
  assign done        = done_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = MAC;
        else       state_nxt_s = IDLE;
      end
      MAC: begin
        if (lane_r == LAST_LANE) state_nxt_s = OUT;
        else                     state_nxt_s = MAC;
      end
      OUT: begin
        if (ser_last_s) state_nxt_s = IDLE;
        else            state_nxt_s = OUT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // The accumulator seeds from the post-beat bias so a bias byte arriving with start counts.
  always_comb begin
    if (load_fire_s && (in_sel == SEL_BIAS)) bias_nxt_s = ACC_W'({bias_r, in_data});
    else                                     bias_nxt_s = bias_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        data_r[i]   <= {DATA_W{1'b0}};
        weight_r[i] <= {DATA_W{1'b0}};
      end
      bias_r <= {ACC_W{1'b0}};
    end else begin
      bias_r <= bias_nxt_s;
      if (load_fire_s) begin
        case (in_sel)
          SEL_DATA: begin
            data_r[0] <= in_data[DATA_W-1:0];
            for (int i = 1; i < LANES; i++) data_r[i] <= data_r[i-1];
          end
          SEL_WEIGHT: begin
            weight_r[0] <= in_data[DATA_W-1:0];
            for (int i = 1; i < LANES; i++) weight_r[i] <= weight_r[i-1];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    if (signed_r) begin
      op_a_s = $signed({data_r[lane_r][DATA_W-1], data_r[lane_r]});
      op_b_s = $signed({weight_r[lane_r][DATA_W-1], weight_r[lane_r]});
    end else begin
      op_a_s = $signed({1'b0, data_r[lane_r]});
      op_b_s = $signed({1'b0, weight_r[lane_r]});
    end
    prod_s = PROD_W'(op_a_s) * PROD_W'(op_b_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {ACC_W{1'b0}};
      lane_r   <= {CNT_W{1'b0}};
      signed_r <= 1'b0;
      relu_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r    <= bias_nxt_s;
            lane_r   <= {CNT_W{1'b0}};
            signed_r <= signed_mode;
            relu_r   <= relu_en;
          end
        end
        MAC: begin
          acc_r  <= acc_r + ACC_W'(prod_s);
          lane_r <= lane_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (relu_r && signed_r && acc_r[ACC_W-1]) result_s = {ACC_W{1'b0}};
    else                                      result_s = acc_r;
  end

  // loaded_r gives the serializer exactly one load in the first OUT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      loaded_r <= (state_r == OUT) & ~ser_last_s;
      done_r   <= (state_r == OUT) & ser_last_s;
    end
  end

  byte_serializer #(.WIDTH(ACC_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load_s),
    .word      (result_s),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (ser_last_s)
  );

endmodule

// File: tb/tb_neuron_dot_engine.sv
// Self-checking bench: directed scenarios plus random loads against an arithmetic model.
module tb_neuron_dot_engine;
  localparam int LANES = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W = 24;
  localparam int NB = ACC_W / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_sel = 2'd0;
  logic       in_valid = 1'b0, start = 1'b0, signed_mode = 1'b0, relu_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, busy, out_valid, done;
  logic [7:0] out_byte;
  logic [23:0] w;

  int total = 0;
  int bad = 0;
  int m_data[LANES];
  int m_wt[LANES];
  longint m_bias;

  neuron_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .signed_mode(signed_mode), .relu_en(relu_en),
    .busy(busy), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) begin
      m_data[i] = 0;
      m_wt[i] = 0;
    end
    m_bias = 0;
  endtask

  // Offers one beat at the current negedge; the model takes it since the DUT is idle.
  task automatic beat(input logic [1:0] sel, input logic [7:0] b);
    in_sel = sel;
    in_data = b;
    in_valid = 1'b1;
    case (sel)
      2'd0: begin
        for (int i = LANES - 1; i > 0; i--) m_data[i] = m_data[i-1];
        m_data[0] = int'(b);
      end
      2'd1: begin
        for (int i = LANES - 1; i > 0; i--) m_wt[i] = m_wt[i-1];
        m_wt[0] = int'(b);
      end
      2'd2: m_bias = ((m_bias << 8) | longint'(b)) & 64'hFFFFFF;
      default: ;
    endcase
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic longint model_result(input bit s, input bit r);
    longint acc, a, b;
    acc = m_bias;
    for (int k = 0; k < LANES; k++) begin
      a = longint'(m_data[k]);
      b = longint'(m_wt[k]);
      if (s) begin
        if (a > 127) a -= 256;
        if (b > 127) b -= 256;
      end
      acc = (acc + a * b) & 64'hFFFFFF;
    end
    if (r && s && acc[23]) acc = 0;
    return acc;
  endfunction

  task automatic compute(input bit s, input bit r, input int stall_idx, input bit rnd,
                         input bit poke, input int rst_idx, input int beat_byte,
                         output logic [23:0] got);
    longint exp;
    int cycles, idx, guard, holds;
    bit rdy, aborted;
    got = 24'h0;
    signed_mode = s;
    relu_en = r;
    start = 1'b1;
    if (beat_byte >= 0) beat(2'd2, 8'(beat_byte));
    else @(negedge clk);
    start = 1'b0;
    signed_mode = 1'($urandom_range(0, 1));
    relu_en = 1'($urandom_range(0, 1));
    exp = model_result(s, r);
    check_val("busy_mac", 32'(busy), 32'd1);
    check_val("ready_mac", 32'(in_ready), 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      if (poke) begin
        check_val("ready_busy", 32'(in_ready), 32'd0);
        start = 1'b1;
        in_valid = 1'b1;
        in_sel = 2'd0;
        in_data = 8'h99;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check_val("latency", 32'(cycles), 32'(LANES + 1));
    idx = 0;
    guard = 0;
    holds = 0;
    aborted = 1'b0;
    while (idx < NB && guard < 200 && !aborted) begin
      check_val("out_valid", 32'(out_valid), 32'd1);
      check_val($sformatf("byte%0d", idx), 32'(out_byte), 32'((exp >> (8 * (NB - 1 - idx))) & 64'hFF));
      check_val("done_early", 32'(done), 32'd0);
      if (idx == rst_idx) begin
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        if (idx == stall_idx && holds < 3) begin
          rdy = 1'b0;
          holds++;
        end else begin
          rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        out_ready = rdy;
        if (rdy) got = {got[15:0], out_byte};
        @(negedge clk);
        guard++;
        if (rdy) idx++;
      end
    end
    out_ready = 1'b0;
    if (aborted) begin
      repeat (2) begin
        check_val("rst_no_done", 32'(done), 32'd0);
        @(negedge clk);
      end
    end else begin
      check_val("out_timeout", 32'(guard < 200), 32'd1);
      check_val("done", 32'(done), 32'd1);
      check_val("idle_ready", 32'(in_ready), 32'd1);
      check_val("word", 32'(got), 32'(exp));
      @(negedge clk);
      check_val("done_pulse", 32'(done), 32'd0);
      check_val("idle_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_byte", 32'(out_byte), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 1; i <= 4; i++) beat(2'd0, 8'(i));
    for (int i = 5; i <= 8; i++) beat(2'd1, 8'(i));
    repeat (3) beat(2'd2, 8'h00);
    compute(1'b0, 1'b0, -1, 1'b0, 1'b0, -1, -1, w);
    check_val("t_unsigned_dot", 32'(w), 32'h46);

    compute(1'b0, 1'b0, -1, 1'b0, 1'b1, -1, -1, w);
    check_val("t_busy_protect", 32'(w), 32'h46);
    repeat (3) begin
      @(negedge clk);
      check_val("t_no_second", 32'(busy), 32'd0);
    end

    compute(1'b0, 1'b0, 0, 1'b0, 1'b0, -1, -1, w);
    check_val("t_backpressure", 32'(w), 32'h46);

    repeat (4) beat(2'd0, 8'hFF);
    repeat (4) beat(2'd1, 8'h02);
    beat(2'd2, 8'h00);
    beat(2'd2, 8'h00);
    beat(2'd2, 8'h05);
    compute(1'b1, 1'b0, -1, 1'b0, 1'b0, -1, -1, w);
    check_val("t_signed", 32'(w), 32'hFFFFFD);
    compute(1'b1, 1'b1, -1, 1'b0, 1'b0, -1, -1, w);
    check_val("t_signed_relu", 32'(w), 32'h0);

    repeat (4) beat(2'd0, 8'hFF);
    repeat (4) beat(2'd1, 8'hFF);
    repeat (3) beat(2'd2, 8'h00);
    compute(1'b0, 1'b1, -1, 1'b0, 1'b0, -1, -1, w);
    check_val("t_unsigned_max", 32'(w), 32'h03F804);

    beat(2'd3, 8'h12);
    compute(1'b0, 1'b0, -1, 1'b0, 1'b0, -1, -1, w);
    check_val("t_sel_none", 32'(w), 32'h03F804);

    compute(1'b0, 1'b0, -1, 1'b0, 1'b0, -1, 8'h07, w);
    check_val("t_start_with_beat", 32'(w), 32'h03F80B);

    compute(1'b0, 1'b0, -1, 1'b0, 1'b0, 1, -1, w);
    compute(1'b0, 1'b0, -1, 1'b0, 1'b0, -1, -1, w);
    check_val("t_after_reset", 32'(w), 32'h0);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = int'($urandom_range(0, 12));
      for (int j = 0; j < n; j++) beat(2'($urandom_range(0, 3)), 8'($urandom));
      compute(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)) - 1, 1'b1, 1'($urandom_range(0, 1)), -1,
              ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 255)), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
